alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
// - Parametrised, handshaked successor of the front-panel ALU. Executes one XM
//   arithmetic/logic op per transaction on WIDTH-bit operands, word or byte.
// - Produces result plus PSW (V S N Z C); sits between operand fetch and register writeback.
// - Adds over the previous block: async reset, valid/ready handshake, sign-extending SRA,
//   multi-cycle DADD (BCD), CMP with no writeback, carry taken from PSW.
// PARAMETERS
// - WIDTH  16  operand/result width; multiple of 8, >= 16; byte mode always uses bits [7:0]
// PORTS
// - Clock      in   1      rising-edge clock
// - Reset      in   1      asynchronous, active-high; clears all state
// - in_valid   in   1      op/operands valid this cycle
// - in_ready   out  1      block can accept; = !busy
// - op         in   4      opcode (alu_pkg::alu_op_t)
// - byte_mode  in   1      1 = .B variant
// - src        in   WIDTH  source operand
// - dst        in   WIDTH  destination operand
// - psw_i      in   16     current PSW; C in bit 0 feeds ADDC/SUBC/RRC/DADD
// - out_valid  out  1      one-cycle pulse: result/psw_o/res_we valid
// - result     out  WIDTH  registered result, held until the next completion
// - res_we     out  1      1 = write result to dst; 0 for CMP; valid with out_valid
// - psw_o      out  16     registered PSW; bits other than V,N,Z,C copied from psw_i at accept
// BEHAVIOUR
// - Reset: in_ready=1, out_valid=0, result=0, res_we=0, psw_o=0, FSM=IDLE; any DADD is aborted.
// - Accept on rising edge when in_valid & in_ready; operands and psw_i are latched.
// - FSM: IDLE -> (accept, op!=DADD) -> IDLE, out_valid=1 next cycle (latency 1)
//   IDLE -> (accept DADD) -> BCD; one digit per cycle; N=WIDTH/4 (word) or 2 (byte)
//   BCD -> (last digit) -> IDLE, out_valid=1 the cycle after the last digit (latency N).
// - in_ready=0 only in BCD; in_valid ignored then. Back-to-back single-cycle ops are legal
//   every cycle. An accept in the cycle out_valid is high is legal.
// - Eff. width E = 8 (byte) or WIDTH. In byte mode result[WIDTH-1:8] = dst[WIDTH-1:8].
// - Ops: ADD D+S; ADDC D+S+C; SUB D+~S+1; SUBC D+~S+C; CMP = SUB with res_we=0;
//   XOR, AND, BIC (D&~S), BIS (D|S); SRA: r[E-1]=d[E-1], C=d[0];
//   RRC: r[E-1]=C_in, C=d[0]; DADD: BCD D+S+C_in, digit by digit.
// - Flags (bit indices in alu_pkg: C=0 Z=1 N=2 S=3 V=4), computed on E bits.
//   Z = (r[E-1:0]==0); N = r[E-1].
//   Arith: C = carry out of bit E-1 (SUB: 1 = no borrow); V = (d[E-1]==s'[E-1]) & (r[E-1]!=d[E-1]),
//   where s' = S for ADD/ADDC and ~S for SUB/SUBC/CMP.
//   Logic (XOR/AND/BIC/BIS): N,Z updated; C,V = psw_i.
//   SRA/RRC: C = shifted-out bit; V=0.
//   DADD: C = decimal carry out of top digit; V unchanged.
// - Undefined op codes: completes in 1 cycle, res_we=0, psw_o=psw_i, result unchanged.
// - Digit values >9 into DADD: binary-add then +6 correction; no error flag.
// STRUCTURE
// - alu_pkg: alu_op_t enum (ADD ADDC SUB SUBC CMP DADD XOR AND BIC BIS SRA RRC),
//   PSW bit-index constants, FSM state enum {IDLE, BCD}.
// - Sub-module bcd_digit_add: combinational 4-bit digit + carry -> digit + carry;
//   one instance, reused each BCD cycle.
// TESTING
// - ADD 0x7FFF+0x0001, C=0 -> result=0x8000, V=1 N=1 Z=0 C=0, out_valid 1 cycle after accept.
// - ADD.B dst=0x12FF src=0x0001 -> 0x1200, C=1 Z=1 N=0 V=0.
// - SUB and CMP, dst=src=0x0005 -> flags Z=1 C=1 N=0 V=0; SUB res_we=1, CMP res_we=0.
// - DADD dst=0x0999 src=0x0001 C=0 -> 0x1000, C=0. out_valid 4 cycles after accept.
//   in_ready=0 until completion; an in_valid pulse while busy is ignored.
// - SRA 0x8002 -> 0xC001, C=0, N=1. RRC 0x0001 with C=1 -> 0x8000, C=1, N=1.
//   Random back-to-back stream checked against a reference model.
// - Reset raised in DADD cycle 2 -> outputs reset values, no out_valid.
//   After release, ADD 1+1 -> 0x0002 with normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential XM ALU: opcodes, PSW bit indices, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_CMP  = 4'd4,
    OP_DADD = 4'd5,
    OP_XOR  = 4'd6,
    OP_AND  = 4'd7,
    OP_BIC  = 4'd8,
    OP_BIS  = 4'd9,
    OP_SRA  = 4'd10,
    OP_RRC  = 4'd11
  } alu_op_t;

  localparam int PSW_C = 0;
  localparam int PSW_Z = 1;
  localparam int PSW_N = 2;
  localparam int PSW_S = 3;
  localparam int PSW_V = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BCD  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit adder: binary add of two digits plus carry,
// then +6 correction when the binary sum exceeds 9.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] bin;

  assign bin  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
  assign cout = (bin > 5'd9);
  assign sum  = cout ? (bin[3:0] + 4'd6) : bin[3:0];

endmodule

// File: rtl/alu_seq.sv
// Handshaked XM ALU: single-cycle arith/logic/shift ops and a
// digit-serial DADD that stalls the input side while it runs.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             byte_mode,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  input  logic [15:0]      psw_i,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             res_we,
  output logic [15:0]      psw_o
);

  localparam int ND = WIDTH / 4;
  localparam int CW = $clog2(ND);

  alu_op_t    opc;
  alu_state_t state;
  logic       accept;

  assign opc      = alu_op_t'(op);
  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  logic is_add, is_sub, is_arith;
  logic is_xor, is_and, is_bic, is_bis;
  logic is_logic, is_shift, is_def;

  assign is_add   = (opc == OP_ADD) | (opc == OP_ADDC);
  assign is_sub   = (opc == OP_SUB) | (opc == OP_SUBC)
                  | (opc == OP_CMP);
  assign is_arith = is_add | is_sub;
  assign is_xor   = (opc == OP_XOR);
  assign is_and   = (opc == OP_AND);
  assign is_bic   = (opc == OP_BIC);
  assign is_bis   = (opc == OP_BIS);
  assign is_logic = is_xor | is_and | is_bic | is_bis;
  assign is_shift = (opc == OP_SRA) | (opc == OP_RRC);
  assign is_def   = is_arith | is_logic | is_shift;

  logic             c_in;
  logic             cin;
  logic [WIDTH-1:0] s_eff;
  logic [WIDTH:0]   sum_w;
  logic [8:0]       sum_b;
  logic             d_msb, s_msb;

  assign c_in  = psw_i[PSW_C];
  assign cin   = ((opc == OP_ADDC) | (opc == OP_SUBC)) ? c_in
               : is_sub;
  assign s_eff = is_sub ? ~src : src;
  assign sum_w = {1'b0, dst} + {1'b0, s_eff}
               + {{WIDTH{1'b0}}, cin};
  assign sum_b = {1'b0, dst[7:0]} + {1'b0, s_eff[7:0]}
               + {8'd0, cin};
  assign d_msb = byte_mode ? dst[7] : dst[WIDTH-1];
  assign s_msb = byte_mode ? s_eff[7] : s_eff[WIDTH-1];

  logic [WIDTH-1:0] r;
  logic             fill, r_msb, z_new, c_new, v_new;
  logic [15:0]      psw_new;

  always_comb begin
    r       = dst;
    c_new   = psw_i[PSW_C];
    v_new   = psw_i[PSW_V];
    fill    = (opc == OP_SRA) ? d_msb : c_in;
    unique case (1'b1)
      is_arith: r = sum_w[WIDTH-1:0];
      is_xor:   r = dst ^ src;
      is_and:   r = dst & src;
      is_bic:   r = dst & ~src;
      is_bis:   r = dst | src;
      is_shift: r = {1'b0, dst[WIDTH-1:1]};
      default:  r = dst;
    endcase
    if (byte_mode)
      r[WIDTH-1:8] = dst[WIDTH-1:8];
    if (is_shift) begin
      if (byte_mode) r[7] = fill;
      else           r[WIDTH-1] = fill;
      c_new = dst[0];
      v_new = 1'b0;
    end
    r_msb = byte_mode ? r[7] : r[WIDTH-1];
    z_new = byte_mode ? (r[7:0] == 8'd0) : (r == '0);
    if (is_arith) begin
      c_new = byte_mode ? sum_b[8] : sum_w[WIDTH];
      v_new = (d_msb == s_msb) & (r_msb != d_msb);
    end
    psw_new        = psw_i;
    psw_new[PSW_C] = c_new;
    psw_new[PSW_Z] = z_new;
    psw_new[PSW_N] = r_msb;
    psw_new[PSW_V] = v_new;
  end

  // DADD datapath: operands latched, one digit folded in per cycle
  logic [WIDTH-1:0] d_q, s_q, acc, acc_next, r_bcd;
  logic [15:0]      psw_q, psw_bcd;
  logic [CW-1:0]    cnt, last_cnt;
  logic             bcd_c, byte_q;
  logic [3:0]       dig_a, dig_b, dig_s;
  logic             dig_c;

  assign last_cnt = byte_q ? CW'(1) : CW'(ND - 1);
  assign dig_a    = d_q[{cnt, 2'b00} +: 4];
  assign dig_b    = s_q[{cnt, 2'b00} +: 4];

  bcd_digit_add u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (bcd_c),
    .sum  (dig_s),
    .cout (dig_c)
  );

  always_comb begin
    acc_next = acc;
    acc_next[{cnt, 2'b00} +: 4] = dig_s;
    r_bcd = byte_q ? {d_q[WIDTH-1:8], acc_next[7:0]}
                   : acc_next;
    psw_bcd        = psw_q;
    psw_bcd[PSW_C] = dig_c;
    psw_bcd[PSW_Z] = byte_q ? (r_bcd[7:0] == 8'd0)
                            : (r_bcd == '0);
    psw_bcd[PSW_N] = byte_q ? r_bcd[7] : r_bcd[WIDTH-1];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      res_we    <= 1'b0;
      psw_o     <= '0;
      d_q       <= '0;
      s_q       <= '0;
      acc       <= '0;
      psw_q     <= '0;
      cnt       <= '0;
      bcd_c     <= 1'b0;
      byte_q    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && opc == OP_DADD) begin
            state  <= BCD;
            d_q    <= dst;
            s_q    <= src;
            acc    <= '0;
            psw_q  <= psw_i;
            cnt    <= '0;
            bcd_c  <= c_in;
            byte_q <= byte_mode;
          end else if (accept) begin
            out_valid <= 1'b1;
            if (is_def) begin
              result <= r;
              res_we <= (opc != OP_CMP);
              psw_o  <= psw_new;
            end else begin
              res_we <= 1'b0;
              psw_o  <= psw_i;
            end
          end
        end
        BCD: begin
          acc   <= acc_next;
          bcd_c <= dig_c;
          cnt   <= cnt + 1'b1;
          if (cnt == last_cnt) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            result    <= r_bcd;
            res_we    <= 1'b1;
            psw_o     <= psw_bcd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus randomized streams
// checked against an integer-arithmetic reference model.
module tb_alu_seq;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        byte_mode = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [15:0] src = '0;
  logic [15:0] dst = '0;
  logic [15:0] psw_i = '0;
  logic        in_ready, out_valid, res_we;
  logic [15:0] result, psw_o;

  int passed = 0;
  int total  = 0;

  alu_seq #(.WIDTH(16)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .byte_mode (byte_mode),
    .src       (src),
    .dst       (dst),
    .psw_i     (psw_i),
    .out_valid (out_valid),
    .result    (result),
    .res_we    (res_we),
    .psw_o     (psw_o)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic void ref_model(
    input int opn, input bit bm,
    input logic [15:0] d, input logic [15:0] s,
    input logic [15:0] ps, input logic [15:0] prev,
    output logic [15:0] r, output logic [15:0] p,
    output bit we);
    int e, m, dv, sv, c, sp, full, rv, cy, nb, ds;
    bit arith, logic_op, shift;
    e = bm ? 8 : 16;
    m = (1 << e) - 1;
    dv = d & m;
    sv = s & m;
    c = ps[0];
    sp = sv; full = 0; cy = 0;
    arith = 0; logic_op = 0; shift = 0;
    case (opn)
      0: begin full = dv + sv; arith = 1; end
      1: begin full = dv + sv + c; arith = 1; end
      2, 4: begin
        sp = ~sv & m; full = dv + sp + 1; arith = 1;
      end
      3: begin sp = ~sv & m; full = dv + sp + c; arith = 1; end
      5: begin
        cy = c;
        for (int k = 0; k < e / 4; k++) begin
          int t;
          t = ((dv >> (4 * k)) & 15) + ((sv >> (4 * k)) & 15) + cy;
          if (t > 9) begin t = t + 6; cy = 1; end
          else cy = 0;
          full = full | ((t & 15) << (4 * k));
        end
      end
      6: begin full = dv ^ sv; logic_op = 1; end
      7: begin full = dv & sv; logic_op = 1; end
      8: begin full = dv & ~sv & m; logic_op = 1; end
      9: begin full = dv | sv; logic_op = 1; end
      10: begin
        full = (dv >> 1) | (dv & (1 << (e - 1)));
        cy = dv & 1; shift = 1;
      end
      11: begin
        full = (dv >> 1) | (c << (e - 1));
        cy = dv & 1; shift = 1;
      end
      default: begin
        r = prev; p = ps; we = 0;
        return;
      end
    endcase
    rv = full & m;
    nb = (rv >> (e - 1)) & 1;
    r = bm ? ((d & 16'hFF00) | 16'(rv)) : 16'(rv);
    p = ps;
    p[1] = (rv == 0);
    p[2] = nb[0];
    if (arith) begin
      ds = (dv >> (e - 1)) & 1;
      p[0] = (full >> e) & 1;
      p[4] = (ds == ((sp >> (e - 1)) & 1)) && (nb != ds);
    end else if (shift) begin
      p[0] = cy[0];
      p[4] = 1'b0;
    end else if (!logic_op) begin
      p[0] = cy[0];
    end
    we = (opn != 4);
  endfunction

  task automatic drive(input int o, input bit bm,
                       input logic [15:0] d, input logic [15:0] s,
                       input logic [15:0] p);
    op = 4'(o); byte_mode = bm;
    dst = d; src = s; psw_i = p;
    in_valid = 1'b1;
    @(posedge Clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge Clock);
    #1;
    total++;
    if ({in_ready, out_valid, res_we} !== 3'b100)
      $display("FAIL reset_ctl got rdy=%b ov=%b we=%b exp 1 0 0",
               in_ready, out_valid, res_we);
    else passed++;
    total++;
    if (result !== 16'h0 || psw_o !== 16'h0)
      $display("FAIL reset_data got res=%h psw=%h exp 0 0",
               result, psw_o);
    else passed++;
    Reset = 1'b0;
  endtask

  task automatic test_add_overflow;
    drive(0, 0, 16'h7FFF, 16'h0001, 16'h0000);
    total++;
    if (out_valid !== 1'b1)
      $display("FAIL add_latency got ov=%b exp 1", out_valid);
    else passed++;
    total++;
    if (result !== 16'h8000 || psw_o !== 16'h0014 || res_we !== 1'b1)
      $display("FAIL add_ovf got %h psw %h we %b exp 8000 0014 1",
               result, psw_o, res_we);
    else passed++;
    @(posedge Clock); #1;
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL add_pulse got ov=%b exp 0", out_valid);
    else passed++;
  endtask

  task automatic test_add_byte;
    drive(0, 1, 16'h12FF, 16'h0001, 16'h0000);
    total++;
    if (result !== 16'h1200 || psw_o !== 16'h0003)
      $display("FAIL add_byte got %h psw %h exp 1200 0003",
               result, psw_o);
    else passed++;
  endtask

  task automatic test_sub_cmp;
    drive(2, 0, 16'h0005, 16'h0005, 16'h0000);
    total++;
    if (result !== 16'h0 || psw_o !== 16'h0003 || res_we !== 1'b1)
      $display("FAIL sub_eq got %h psw %h we %b exp 0000 0003 1",
               result, psw_o, res_we);
    else passed++;
    drive(4, 0, 16'h0005, 16'h0005, 16'h0000);
    total++;
    if (psw_o !== 16'h0003 || res_we !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL cmp_eq got psw %h we %b ov %b exp 0003 0 1",
               psw_o, res_we, out_valid);
    else passed++;
  endtask

  task automatic test_shifts;
    drive(10, 0, 16'h8002, 16'h0000, 16'h0000);
    total++;
    if (result !== 16'hC001 || psw_o !== 16'h0004)
      $display("FAIL sra got %h psw %h exp c001 0004", result, psw_o);
    else passed++;
    drive(11, 0, 16'h0001, 16'h0000, 16'h0001);
    total++;
    if (result !== 16'h8000 || psw_o !== 16'h0005)
      $display("FAIL rrc got %h psw %h exp 8000 0005", result, psw_o);
    else passed++;
  endtask

  task automatic test_dadd;
    int cyc;
    drive(5, 0, 16'h0999, 16'h0001, 16'h0000);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL dadd_busy got rdy=%b ov=%b exp 0 0",
               in_ready, out_valid);
    else passed++;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      if (cyc == 1) begin
        in_valid = 1'b1; op = 4'd0;
        dst = 16'h0001; src = 16'h0001;
      end
      @(posedge Clock); #1;
      in_valid = 1'b0;
      cyc++;
    end
    total++;
    if (cyc !== 4)
      $display("FAIL dadd_latency got %0d exp 4", cyc);
    else passed++;
    total++;
    if (result !== 16'h1000 || psw_o !== 16'h0000 || res_we !== 1'b1)
      $display("FAIL dadd_res got %h psw %h we %b exp 1000 0000 1",
               result, psw_o, res_we);
    else passed++;
    @(posedge Clock); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL dadd_ignored got ov=%b rdy=%b exp 0 1",
               out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_random_stream;
    logic [15:0] er, ep, prev, d, s, p;
    bit ew, bm;
    int o;
    drive(0, 0, 16'h0000, 16'h0000, 16'h0000);
    total++;
    if (result !== 16'h0000)
      $display("FAIL stream_seed got %h exp 0000", result);
    else passed++;
    prev = 16'h0000;
    o = $urandom_range(0, 14);
    if (o >= 5) o++;
    bm = 1'($urandom); d = 16'($urandom);
    s = 16'($urandom); p = 16'($urandom);
    op = 4'(o); byte_mode = bm; dst = d; src = s; psw_i = p;
    in_valid = 1'b1;
    ref_model(o, bm, d, s, p, prev, er, ep, ew);
    for (int i = 0; i < 40; i++) begin
      @(posedge Clock); #1;
      total++;
      if (out_valid !== 1'b1)
        $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid);
      else passed++;
      total++;
      if ({result, psw_o, res_we} !== {er, ep, ew})
        $display("FAIL stream[%0d] op %0d b %b got %h %h %b exp %h %h %b",
                 i, o, bm, result, psw_o, res_we, er, ep, ew);
      else passed++;
      prev = er;
      if (i < 39) begin
        o = $urandom_range(0, 14);
        if (o >= 5) o++;
        bm = 1'($urandom); d = 16'($urandom);
        s = 16'($urandom); p = 16'($urandom);
        op = 4'(o); byte_mode = bm; dst = d; src = s; psw_i = p;
        ref_model(o, bm, d, s, p, prev, er, ep, ew);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_dadd_random;
    logic [15:0] er, ep, d, s, p;
    bit ew, bm;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      bm = 1'($urandom); d = 16'($urandom);
      s = 16'($urandom); p = 16'($urandom);
      ref_model(5, bm, d, s, p, 16'h0, er, ep, ew);
      drive(5, bm, d, s, p);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
        @(posedge Clock); #1;
        cyc++;
      end
      total++;
      if (cyc !== (bm ? 2 : 4))
        $display("FAIL dadd_rnd_lat[%0d] got %0d exp %0d",
                 i, cyc, bm ? 2 : 4);
      else passed++;
      total++;
      if ({result, psw_o, res_we} !== {er, ep, ew})
        $display("FAIL dadd_rnd[%0d] got %h %h %b exp %h %h %b",
                 i, result, psw_o, res_we, er, ep, ew);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_dadd;
    int seen;
    drive(5, 0, 16'h1234, 16'h5678, 16'h0000);
    @(posedge Clock); #1;
    Reset = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, res_we} !== 3'b100 ||
        result !== 16'h0 || psw_o !== 16'h0)
      $display("FAIL rst_mid got rdy=%b ov=%b we=%b res=%h psw=%h exp 1 0 0 0 0",
               in_ready, out_valid, res_we, result, psw_o);
    else passed++;
    @(posedge Clock); #1;
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #1;
      if (out_valid === 1'b1) seen++;
    end
    total++;
    if (seen !== 0)
      $display("FAIL rst_abort got %0d pulses exp 0", seen);
    else passed++;
    drive(0, 0, 16'h0001, 16'h0001, 16'h0000);
    total++;
    if (out_valid !== 1'b1 || result !== 16'h0002 || psw_o !== 16'h0)
      $display("FAIL rst_after got ov=%b %h psw %h exp 1 0002 0000",
               out_valid, result, psw_o);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_add_byte;
    test_sub_cmp;
    test_shifts;
    test_dadd;
    test_random_stream;
    test_dadd_random;
    test_reset_mid_dadd;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
